// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment driver. Values are loaded through a load/busy handshake,
// converted to hex or double-dabble BCD, and committed atomically to the scanned digit registers.
module ssd_scan_driver #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  input  logic              signed_mode,
  input  logic              hex_mode,
  output logic              busy,
  output logic              overflow,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int unsigned BCD_D  = (DATA_W * 77) / 256 + 2;
  localparam int unsigned NIB    = (DATA_W + 4) / 4;
  localparam int unsigned ND_A   = (NIB > BCD_D) ? NIB : BCD_D;
  localparam int unsigned ND     = (ND_A > DIGITS) ? ND_A : DIGITS;
  localparam int unsigned SW     = 4 * ND;
  localparam int unsigned CNT_W  = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W  = $clog2(DIGITS);
  localparam int unsigned CYC_W  = $clog2(DATA_W + 1);
  localparam logic [6:0]  G_BLANK = 7'b1111111;
  localparam logic [6:0]  G_MINUS = 7'b0111111;
  localparam logic [6:0]  G_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CONV, S_COMMIT} state_t;

  state_t                       state_q, state_d;
  logic [DATA_W-1:0]            val_q, val_d;
  logic                         sgn_q, sgn_d, hex_q, hex_d, neg_q, neg_d;
  logic [DATA_W:0]              mag_q, mag_d, ext;
  logic [4*BCD_D-1:0]           bcd_q, bcd_d, adj;
  logic [CYC_W-1:0]             cyc_q, cyc_d;
  logic                         ovf_q, ovf_d, ovf_c;
  logic [DIGITS-1:0][6:0]       disp_q, disp_d, img;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [SW-1:0]                src;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // Display image and overflow derived from the converted digits; consumed only in COMMIT.
  always_comb begin
    int unsigned avail;
    int unsigned msd;
    src   = hex_q ? SW'(mag_q) : SW'(bcd_q);
    avail = neg_q ? DIGITS - 1 : DIGITS;
    ovf_c = 1'b0;
    msd   = 0;
    img   = '1;
    for (int unsigned i = 0; i < ND; i++) begin
      if (src[4*i +: 4] != 4'h0) begin
        msd = i;
        if (i >= avail) ovf_c = 1'b1;
      end
    end
    for (int unsigned p = 0; p < DIGITS; p++) begin
      if (ovf_c || (neg_q && p == DIGITS - 1)) img[p] = G_MINUS;
      else if (p <= msd)                       img[p] = glyph(src[4*p +: 4]);
      else                                     img[p] = G_BLANK;
    end
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    sgn_d   = sgn_q;
    hex_d   = hex_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    cyc_d   = cyc_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    ext     = sgn_q ? {val_q[DATA_W-1], val_q} : {1'b0, val_q};
    adj     = bcd_q;
    for (int unsigned i = 0; i < BCD_D; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      S_IDLE: begin
        if (load) begin
          val_d   = value;
          sgn_d   = signed_mode;
          hex_d   = hex_mode;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        // One extra magnitude bit keeps the most-negative input exact.
        neg_d   = sgn_q & val_q[DATA_W-1];
        mag_d   = neg_d ? ('0 - ext) : ext;
        bcd_d   = '0;
        cyc_d   = '0;
        state_d = hex_q ? S_COMMIT : S_CONV;
      end
      S_CONV: begin
        bcd_d = {adj[4*BCD_D-2:0], mag_q[DATA_W-1]};
        mag_d = mag_q << 1;
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_q == CYC_W'(DATA_W - 1)) state_d = S_COMMIT;
      end
      default: begin
        ovf_d   = ovf_c;
        disp_d  = img;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      sgn_q   <= 1'b0;
      hex_q   <= 1'b0;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cyc_q   <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= {{(DIGITS-1){G_BLANK}}, G_ZERO};
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      sgn_q   <= sgn_d;
      hex_q   <= hex_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      cyc_q   <= cyc_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign overflow = ovf_q;
  assign an       = ~(DIGITS'(1) << idx_q);
  assign seg      = disp_q[idx_q];

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: stimulus queues expected display images,
// a monitor pops one whenever a conversion completes (or a snapshot is requested) and scans it.
module tb_ssd_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load, signed_mode, hex_mode;
  logic        busy, overflow;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        snap_req = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               busy_len;
    logic             ovf;
    logic [3:0][6:0]  d;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;

  ssd_scan_driver #(.DATA_W(16), .DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .signed_mode(signed_mode), .hex_mode(hex_mode),
    .busy(busy), .overflow(overflow), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor
  initial begin
    int          bcnt;
    logic        prev;
    logic [6:0]  cap [4];
    bit          seen [4];
    exp_t        e;
    int          idx;
    bcnt = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0;
        prev = 1'b0;
      end else begin
        if (busy) bcnt++;
        if ((prev && !busy) || snap_req) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got a result with busy_len=%0d, required none", bcnt);
          end else begin
            e = exp_q.pop_front();
            if (e.busy_len >= 0) begin
              checks++;
              if (bcnt != e.busy_len) begin
                errors++;
                $display("FAIL busy_len: got %0d, required %0d", bcnt, e.busy_len);
              end
            end
            checks++;
            if (overflow !== e.ovf) begin
              errors++;
              $display("FAIL overflow: got %b, required %b", overflow, e.ovf);
            end
            for (int j = 0; j < 4; j++) seen[j] = 1'b0;
            for (int k = 0; k < 16; k++) begin
              if (k > 0) @(negedge clk);
              idx = -1;
              for (int j = 0; j < 4; j++) if (an === ~(4'b0001 << j)) idx = j;
              checks++;
              if (idx < 0) begin
                errors++;
                $display("FAIL an_onehot: got %b, required one-hot-low", an);
              end else begin
                cap[idx]  = seg;
                seen[idx] = 1'b1;
              end
            end
            for (int j = 0; j < 4; j++) begin
              checks++;
              if (!seen[j] || cap[j] !== e.d[j]) begin
                errors++;
                $display("FAIL digit%0d: got %b (seen=%0d), required %b", j, cap[j], seen[j], e.d[j]);
              end
            end
          end
          bcnt = 0;
        end
        prev = busy;
      end
    end
  end

  task automatic push(input int bl, input logic o, input logic [6:0] d0, d1, d2, d3);
    exp_t e;
    e.busy_len = bl;
    e.ovf      = o;
    e.d        = {d3, d2, d1, d0};
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] v, input logic s, input logic h);
    @(negedge clk);
    value = v; signed_mode = s; hex_mode = h; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (24) @(posedge clk);
  endtask

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  initial begin
    logic [3:0] ean;
    rst_n = 1'b0; load = 1'b0; value = '0; signed_mode = 1'b0; hex_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_an",   7'(an), 7'b0001110);
    chk("reset_seg",  seg, 7'b1000000);
    chk("reset_busy", 7'(busy), 7'd0);
    chk("reset_ovf",  7'(overflow), 7'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      ean = ~(4'b0001 << ((k / 4) % 4));
      chk("scan_an", 7'(an), 7'(ean));
      chk("scan_seg", seg, (ean == 4'b1110) ? 7'b1000000 : BL);
    end
    chk("idle_busy", 7'(busy), 7'd0);
    chk("idle_ovf",  7'(overflow), 7'd0);

    push(2, 1'b0, 7'b0010010, 7'b0001000, BL, BL);
    do_load(16'h00A5, 1'b0, 1'b1);
    wait_idle();

    push(18, 1'b0, 7'b0100100, 7'b0011001, BL, MI);
    do_load(16'hFFD6, 1'b1, 1'b0);
    wait_idle();

    push(18, 1'b1, MI, MI, MI, MI);
    do_load(16'd12345, 1'b0, 1'b0);
    wait_idle();

    push(18, 1'b1, MI, MI, MI, MI);
    do_load(16'h8000, 1'b1, 1'b0);
    wait_idle();

    push(2, 1'b0, 7'b1111001, BL, BL, MI);
    do_load(16'hFFFF, 1'b1, 1'b1);
    wait_idle();

    // 99 decimal; a hex load of 7 mid-conversion must be dropped
    push(18, 1'b0, 7'b0010000, 7'b0010000, BL, BL);
    do_load(16'd99, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 value = 16'h0007; hex_mode = 1'b1; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    wait_idle();

    // Reset during CONV cycle 5 abandons the conversion
    do_load(16'd1234, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 7'(busy), 7'd0);
    chk("midrst_ovf",  7'(overflow), 7'd0);
    chk("midrst_an",   7'(an), 7'b0001110);
    chk("midrst_seg",  seg, 7'b1000000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    push(-1, 1'b0, 7'b1000000, BL, BL, BL);
    @(posedge clk);
    #1 snap_req = 1'b1;
    @(posedge clk);
    #1 snap_req = 1'b0;
    repeat (24) @(posedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
